// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The execute stage is master; the unit itself is slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Optional MDU_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sum, shl, diff;
  logic [2*WIDTH-1:0] pn, prod, prod_fix;
`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] rest;
`endif

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    low_d    = low_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    // op[0]=0 selects the signed variants
    sign_a = bus.srcA[WIDTH-1] & ~bus.op[0];
    sign_b = bus.srcB[WIDTH-1] & ~bus.op[0];
    abs_a  = sign_a ? -bus.srcA : bus.srcA;
    abs_b  = sign_b ? -bus.srcB : bus.srcB;

    // Multiply step: {acc, low} holds the partial product over the unconsumed multiplier
    sum  = {1'b0, acc_q} + {1'b0, (low_q[0] ? opnd_q : '0)};
    pn   = {sum, low_q[WIDTH-1:1]};
    // Divide step: restoring subtract, dividend bits leave low MSB-first
    shl  = {acc_q, low_q[WIDTH-1]};
    diff = shl - {1'b0, opnd_q};

    prod     = {acc_q, low_q};
    prod_fix = neg_q ? -prod : prod;
`ifdef MDU_EARLY_OUT_EN
    rest = (low_q >> 1) & ({WIDTH{1'b1}} >> (cnt_q + 1'b1));
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = CALC;
          is_div_d = bus.op[1];
          neg_d    = sign_a ^ sign_b;
          negr_d   = sign_a;
          dz_d     = bus.op[1] && (bus.srcB == '0);
          opnd_d   = bus.op[1] ? abs_b : abs_a;
          low_d    = bus.op[1] ? abs_a : abs_b;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          if (bus.mthi) hi_d = bus.srcA;
          if (bus.mtlo) lo_d = bus.srcA;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          {acc_d, low_d} = pn;
`ifdef MDU_EARLY_OUT_EN
          // Remaining iterations would only shift right; apply them all now
          if (rest == '0) begin
            {acc_d, low_d} = pn >> (CNT_W'(WIDTH - 1) - cnt_q);
            state_d        = FIX;
          end
`endif
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Zero divisor leaves |dividend| as remainder; sign fix restores srcA exactly
          lo_d = dz_q ? '1 : (neg_q ? -low_q : low_q);
          hi_d = negr_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {h, l} = p;
      end
      2'b01: begin
        pu = {32'h0, a} * {32'h0, b};
        {h, l} = pu;
      end
      2'b10: begin
        if (b == 32'h0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'h0; l = 32'h8000_0000;
        end else begin
          sa = a; sb = b;
          l = sa / sb;
          h = sa % sb;
        end
      end
      default: begin
        if (b == 32'h0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    int          n;
    exp_lat = 33;
    m = b;
    n = 0;
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      if (op == 2'b00 && b[31]) m = -b;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      exp_lat = (n == 0) ? 2 : n + 1;
    end
`endif
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srcA  = a;
    bus.srcB  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called lat0 cycles after the start edge, all of which were busy
  task automatic finish_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat0);
    logic [31:0] eh, el, hold_hi, hold_lo;
    int          lat, busyc;
    logic        leak;
    model(op, a, b, eh, el);
    lat = lat0; busyc = lat0; leak = 1'b0;
    hold_hi = bus.hi; hold_lo = bus.lo;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busyc++;
      if (bus.hi !== hold_hi || bus.lo !== hold_lo) leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat(op, b)));
    check({tag, ":busy_cycles"}, 64'(busyc), 64'(exp_lat(op, b)));
    check({tag, ":busy_at_done"}, 64'(bus.busy), 64'(0));
    check({tag, ":hilo_held"}, 64'(leak), 64'(0));
    check({tag, ":hi"}, 64'(bus.hi), 64'(eh));
    check({tag, ":lo"}, 64'(bus.lo), 64'(el));
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    launch(op, a, b);
    finish_op(tag, op, a, b, 0);
  endtask

  initial begin
    logic [31:0] a, b, prev;
    logic [1:0]  op;
    int          dones;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.srcA = '0; bus.srcB = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:hi", 64'(bus.hi), 64'(0));
    check("reset:lo", 64'(bus.lo), 64'(0));
    check("reset:busy", 64'(bus.busy), 64'(0));
    check("reset:done", 64'(bus.done), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Moves in IDLE
    prev = bus.lo;
    bus.mthi = 1'b1; bus.srcA = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    check("mthi:hi", 64'(bus.hi), 64'(32'hA5A5_A5A5));
    check("mthi:lo", 64'(bus.lo), 64'(prev));
    check("mthi:done", 64'(bus.done), 64'(0));
    bus.mtlo = 1'b1; bus.srcA = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    check("mtlo:lo", 64'(bus.lo), 64'(32'h5A5A_5A5A));
    check("mtlo:hi", 64'(bus.hi), 64'(32'hA5A5_A5A5));
    check("mtlo:done", 64'(bus.done), 64'(0));
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.srcA = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthilo:hi", 64'(bus.hi), 64'(32'h0F0F_0F0F));
    check("mthilo:lo", 64'(bus.lo), 64'(32'h0F0F_0F0F));
    check("mthilo:done", 64'(bus.done), 64'(0));

    // MULTU 2x3 with a move and a second start injected while busy
    launch(2'b01, 32'd2, 32'd3);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mtlo = 1'b1; bus.op = 2'b11;
    bus.srcA = 32'hDEAD_BEEF; bus.srcB = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mtlo = 1'b0;
    check("busy_move:lo", 64'(bus.lo), 64'(32'h0F0F_0F0F));
    finish_op("multu_inject", 2'b01, 32'd2, 32'd3, 2);

    // start together with mthi: start wins
    prev = bus.hi;
    bus.mthi = 1'b1;
    launch(2'b01, 32'd4, 32'd5);
    bus.mthi = 1'b0;
    check("start_mthi:hi", 64'(bus.hi), 64'(prev));
    finish_op("start_mthi", 2'b01, 32'd4, 32'd5, 0);

    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'h0);
    run_op("div_neg_by0", 2'b10, 32'hFFFF_FF00, 32'h0);
    run_op("multu_5x3", 2'b01, 32'd5, 32'd3);
    run_op("mult_by0", 2'b00, 32'h1234_5678, 32'h0);
    run_op("mult_bneg", 2'b00, 32'd9, 32'hFFFF_FFFE);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 255);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op("random", op, a, b);
    end

    // Reset during a divide aborts without a done pulse
    launch(2'b11, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort:hi", 64'(bus.hi), 64'(0));
    check("abort:lo", 64'(bus.lo), 64'(0));
    check("abort:busy", 64'(bus.busy), 64'(0));
    check("abort:done", 64'(bus.done), 64'(0));
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    check("abort:no_done", 64'(dones), 64'(0));
    check("abort:idle", 64'(bus.busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
